// File: rtl/instr_prefetch_buffer.sv
// rtl/instr_prefetch_buffer.sv - instruction prefetch FIFO with single-outstanding memory fetch FSM
module instr_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL    = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic [31:0]   pc_q  [DEPTH];
  logic [31:0]   ins_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   filled;
  logic [PW:0]   count_nxt;
  logic          grant;
  logic          push;
  logic          pop;
  logic          slot_free;

  assign mem_req    = (state == REQ);
  assign mem_addr   = fetch_pc;
  assign inst_valid = (filled != '0);
  assign inst_out   = ins_q[rd_ptr];
  assign inst_pc    = pc_q[rd_ptr];

  assign grant = mem_req & mem_gnt;
  assign pop   = inst_valid & inst_ready & ~redirect;
  assign push  = (state == WAIT) & mem_rvalid & ~redirect & (filled != FULL);

  // count reserves a slot at grant time, so the response always has room
  always_comb begin
    count_nxt = count;
    if (grant) count_nxt = count_nxt + CNT_ONE;
    if (pop)   count_nxt = count_nxt - CNT_ONE;
  end

  assign slot_free = (count_nxt != FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      filled      <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      filled   <= '0;
      case (state)
        REQ:     state <= mem_gnt    ? DISCARD : REQ;
        WAIT:    state <= mem_rvalid ? REQ     : DISCARD;
        IDLE:    state <= REQ;
        DISCARD: state <= mem_rvalid ? REQ     : DISCARD;
        default: state <= REQ;
      endcase
    end else begin
      count <= count_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   filled <= filled + CNT_ONE;
        2'b01:   filled <= filled - CNT_ONE;
        default: filled <= filled;
      endcase
      case (state)
        REQ: begin
          if (mem_gnt) begin
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rvalid) state <= slot_free ? REQ : IDLE;
        end
        IDLE: begin
          if (slot_free) state <= REQ;
        end
        DISCARD: begin
          if (mem_rvalid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]  <= '0;
        ins_q[i] <= '0;
      end
    end else if (push) begin
      pc_q[wr_ptr]  <= inflight_pc;
      ins_q[wr_ptr] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb/tb_instr_prefetch_buffer.sv - randomized scoreboard bench for instr_prefetch_buffer
module tb_instr_prefetch_buffer;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;

  always #5 clk = ~clk;

  instr_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_out(inst_out), .inst_pc(inst_pc)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // memory model: one outstanding response, returned lat_lo..lat_hi cycles after grant
  logic        pend;
  int          pend_wait;
  logic [31:0] pend_data;
  int          gnt_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic        stale_next;

  // reference model: expected fetch stream and delivered stream
  logic [31:0] exp_fetch;
  logic [31:0] exp_pop;
  int          outst;
  logic        prev_stall;
  logic [31:0] prev_addr;
  int          cyc;
  int          n_grants;
  int          n_pops;
  logic [31:0] last_gnt_addr;
  logic        seen_stale;
  int          first_valid_cyc;
  logic [31:0] pop_log[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic model_clear();
    pend = 1'b0; pend_wait = 0; pend_data = '0; stale_next = 1'b0;
    exp_fetch = RESET_PC; exp_pop = RESET_PC; outst = 0;
    prev_stall = 1'b0; prev_addr = '0; cyc = 0; n_grants = 0; n_pops = 0;
    last_gnt_addr = '0; seen_stale = 1'b0; first_valid_cyc = -1;
    pop_log.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // one clock cycle: drive memory, score outputs, advance models, move to next negedge
  task automatic run_cycle();
    logic gr, pp;
    mem_rvalid = pend && (pend_wait == 0);
    mem_rdata  = mem_rvalid ? pend_data : $urandom;
    mem_gnt    = (int'($urandom_range(99)) < gnt_pct);
    #1;
    cyc++;
    gr = mem_req && mem_gnt;
    pp = inst_valid && inst_ready && !redirect;
    if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (inst_valid && inst_out === 32'hDEADBEEF) seen_stale = 1'b1;
    if (prev_stall) begin
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL stall_hold: req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, prev_addr);
      end
    end
    if (gr) begin
      n_cmp++;
      if (mem_addr !== exp_fetch) begin
        n_fail++;
        $display("FAIL fetch_addr: got %h, required %h", mem_addr, exp_fetch);
      end
      n_cmp++;
      if (pend || outst >= DEPTH) begin
        n_fail++;
        $display("FAIL req_overlap: pending=%b reserved=%0d, required pending=0 reserved<%0d", pend, outst, DEPTH);
      end
    end
    if (pp) begin
      n_cmp++;
      if (inst_pc !== exp_pop) begin
        n_fail++;
        $display("FAIL pop_pc: got %h, required %h", inst_pc, exp_pop);
      end
      n_cmp++;
      if (inst_out !== memf(exp_pop)) begin
        n_fail++;
        $display("FAIL pop_data: got %h, required %h", inst_out, memf(exp_pop));
      end
      pop_log.push_back(inst_pc);
      n_pops++;
    end
    if (mem_rvalid) pend = 1'b0;
    else if (pend) pend_wait--;
    if (gr) begin
      pend = 1'b1;
      pend_wait = int'($urandom_range(lat_hi - 1, lat_lo - 1));
      pend_data = stale_next ? 32'hDEADBEEF : memf(mem_addr);
      stale_next = 1'b0;
      n_grants++;
      last_gnt_addr = mem_addr;
    end
    if (redirect) begin
      exp_fetch = redirect_pc; exp_pop = redirect_pc; outst = 0;
    end else begin
      if (gr) begin exp_fetch = exp_fetch + 32'd4; outst++; end
      if (pp) begin exp_pop = exp_pop + 32'd4; outst--; end
    end
    prev_stall = mem_req && !mem_gnt && !redirect;
    prev_addr  = mem_addr;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL reset_mem_req: got %b, required 1", mem_req); end
    n_cmp++; if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_mem_addr: got %h, required %h", mem_addr, RESET_PC); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
    n_cmp++; if (inst_out !== 32'h0) begin n_fail++; $display("FAIL reset_inst_out: got %h, required 0", inst_out); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst_pc: got %h, required 0", inst_pc); end
    @(negedge clk);
  endtask

  task automatic test_cold_start();
    do_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; inst_ready = 1'b1;
    repeat (20) run_cycle();
    n_cmp++;
    if (first_valid_cyc != 3) begin n_fail++; $display("FAIL cold_first_valid: cycle %0d, required 3", first_valid_cyc); end
    n_cmp++;
    if (n_pops != 9) begin n_fail++; $display("FAIL cold_throughput: %0d pops in 20 cycles, required 9", n_pops); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (i >= pop_log.size() || pop_log[i] !== RESET_PC + 32'(4 * i)) begin
        n_fail++;
        $display("FAIL cold_seq[%0d]: got %h, required %h", i, (i < pop_log.size()) ? pop_log[i] : 32'hx, RESET_PC + 32'(4 * i));
      end
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; inst_ready = 1'b0;
    repeat (20) run_cycle();
    n_cmp++; if (n_grants != DEPTH) begin n_fail++; $display("FAIL full_grants: got %0d, required %0d", n_grants, DEPTH); end
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL full_idle_req: got %b, required 0", mem_req); end
    n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL full_valid: got %b, required 1", inst_valid); end
    inst_ready = 1'b1;
    run_cycle();
    inst_ready = 1'b0;
    n_grants = 0;
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
      n_fail++; $display("FAIL refill_req: req=%b addr=%h, required req=1 addr=00000010", mem_req, mem_addr);
    end
    repeat (10) run_cycle();
    n_cmp++; if (n_grants != 1) begin n_fail++; $display("FAIL refill_grants: got %0d, required 1", n_grants); end
    n_cmp++; if (last_gnt_addr !== 32'h10) begin n_fail++; $display("FAIL refill_addr: got %h, required 00000010", last_gnt_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    gnt_pct = 100; lat_lo = 3; lat_hi = 3; inst_ready = 1'b0; stale_next = 1'b1;
    run_cycle();
    n_cmp++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL wait_req: got %b, required 0", mem_req); end
    redirect = 1'b1; redirect_pc = 32'h100;
    run_cycle();
    redirect = 1'b0; lat_lo = 1; lat_hi = 1; inst_ready = 1'b1;
    for (int i = 0; i < 20 && n_pops == 0; i++) run_cycle();
    n_cmp++;
    if (n_pops == 0 || pop_log[0] !== 32'h100) begin
      n_fail++; $display("FAIL redir_wait_pc: pops=%0d first=%h, required first=00000100", n_pops, (n_pops > 0) ? pop_log[0] : 32'hx);
    end
    n_cmp++; if (seen_stale !== 1'b0) begin n_fail++; $display("FAIL redir_wait_stale: stale word presented=%b, required 0", seen_stale); end
    inst_ready = 1'b0;
  endtask

  task automatic test_redirect_pop();
    logic [31:0] rpc;
    do_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; inst_ready = 1'b0;
    repeat (5) run_cycle();
    n_cmp++; if (inst_valid !== 1'b1) begin n_fail++; $display("FAIL rp_pre_valid: got %b, required 1", inst_valid); end
    rpc = $urandom & 32'hFFFF_FFFC;
    redirect = 1'b1; redirect_pc = rpc; inst_ready = 1'b1;
    run_cycle();
    redirect = 1'b0; inst_ready = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rp_flush_valid: got %b, required 0", inst_valid); end
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== rpc) begin
      n_fail++; $display("FAIL rp_new_req: req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, rpc);
    end
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && n_pops == 0; i++) run_cycle();
    n_cmp++;
    if (n_pops == 0 || pop_log[0] !== rpc) begin
      n_fail++; $display("FAIL rp_first_pc: pops=%0d first=%h, required %h", n_pops, (n_pops > 0) ? pop_log[0] : 32'hx, rpc);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_stall_wrap();
    do_reset();
    gnt_pct = 0; lat_lo = 1; lat_hi = 1; inst_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    run_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
        n_fail++; $display("FAIL stall[%0d]: req=%b addr=%h, required req=1 addr=fffffffc", i, mem_req, mem_addr);
      end
      run_cycle();
    end
    gnt_pct = 100;
    run_cycle();
    run_cycle();
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap_addr: req=%b addr=%h, required req=1 addr=00000000", mem_req, mem_addr);
    end
    repeat (3) run_cycle();
    n_cmp++;
    if (n_pops == 0 || pop_log[0] !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap_pop: pops=%0d first=%h, required fffffffc", n_pops, (n_pops > 0) ? pop_log[0] : 32'hx);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_reset_midway();
    do_reset();
    gnt_pct = 100; lat_lo = 1; lat_hi = 1; inst_ready = 1'b0;
    repeat (5) run_cycle();
    n_cmp++;
    if (inst_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL mid_pre: valid=%b req=%b, required valid=1 req=0", inst_valid, mem_req);
    end
    #2;
    rst_n = 1'b0; mem_rvalid = 1'b0; mem_gnt = 1'b0;
    #1;
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b, required 1", mem_req); end
    n_cmp++; if (mem_addr !== RESET_PC) begin n_fail++; $display("FAIL mid_addr: got %h, required %h", mem_addr, RESET_PC); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %b, required 0", inst_valid); end
    n_cmp++; if (inst_out !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL mid_head: out=%h pc=%h, required 0/0", inst_out, inst_pc); end
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    inst_ready = 1'b1;
    repeat (6) run_cycle();
    n_cmp++;
    if (n_pops == 0 || pop_log[0] !== RESET_PC) begin
      n_fail++; $display("FAIL mid_restart: pops=%0d first=%h, required %h", n_pops, (n_pops > 0) ? pop_log[0] : 32'hx, RESET_PC);
    end
    inst_ready = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      gnt_pct = int'($urandom_range(100, 30));
      lat_lo = 1;
      lat_hi = int'($urandom_range(3, 1));
      for (int i = 0; i < 200; i++) begin
        inst_ready  = ($urandom_range(99) < 60);
        redirect    = ($urandom_range(99) < 3);
        redirect_pc = $urandom & 32'hFFFF_FFFC;
        run_cycle();
      end
    end
    redirect = 1'b0; inst_ready = 1'b0;
    n_cmp++; if (n_pops < 100) begin n_fail++; $display("FAIL random_progress: %0d pops, required >= 100", n_pops); end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_cold_start();
    test_backpressure();
    test_redirect_wait();
    test_redirect_pop();
    test_stall_wrap();
    test_reset_midway();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
